// File: rtl/bsg_wire_retime_pkg.sv
// Shared types for the wire retiming skid-buffer slice.
package bsg_wire_retime_pkg;

  localparam int slice_state_width_lp = 2;

  typedef enum logic [slice_state_width_lp-1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } slice_state_e;

endpackage

// File: rtl/bsg_buf.sv
// Payload buffer between the slice head register and its output pins.
module bsg_buf #(
  parameter width_p    = "inv",
  parameter harden_p   = 1,
  parameter vertical_p = 1
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  // Hardened/vertical variants map to placed buffer cells in a physical flow.
  if (harden_p != 0 && vertical_p != 0) begin : g_hard_vert
    assign o = i;
  end else begin : g_soft
    assign o = i;
  end

endmodule

// File: rtl/bsg_wire_retime_slice.sv
// Two-entry valid/ready skid buffer with registered ready_o and 1-cycle latency.
// Optional per-entry even parity enabled by defining BSG_WIRE_RETIME_PARITY_EN.
module bsg_wire_retime_slice
  import bsg_wire_retime_pkg::*;
#(
  parameter width_p    = "inv",
  parameter harden_p   = 1,
  parameter vertical_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               parity_err_o
);

  // state | meaning
  // EMPTY | no words held, v_o=0
  // ONE   | head holds the oldest word
  // FULL  | head and tail both hold words, ready_o=0
  slice_state_e       state_r;
  logic [width_p-1:0] head_r, tail_r;
  logic               v_r, ready_r;
  logic               enq, deq;
  logic               load_head_in, load_tail_in, shift_tail;

  assign enq = v_i & ready_r;
  assign deq = v_r & ready_i;

  assign load_head_in = enq & ((state_r == EMPTY) | ((state_r == ONE) & deq));
  assign load_tail_in = enq & ~deq & (state_r == ONE);
  assign shift_tail   = deq & (state_r == FULL);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
      v_r     <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: if (enq) begin
          head_r  <= data_i;
          state_r <= ONE;
          v_r     <= 1'b1;
        end
        ONE: begin
          if (enq && deq) begin
            head_r <= data_i;
          end else if (enq) begin
            tail_r  <= data_i;
            state_r <= FULL;
            ready_r <= 1'b0;
          end else if (deq) begin
            state_r <= EMPTY;
            v_r     <= 1'b0;
          end
        end
        FULL: if (deq) begin
          head_r  <= tail_r;
          state_r <= ONE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= EMPTY;
          v_r     <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef BSG_WIRE_RETIME_PARITY_EN
  logic head_par_r, tail_par_r, err_r;

  // Parity follows its word through the same head/tail moves as the payload.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_par_r <= 1'b0;
      tail_par_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (load_head_in)    head_par_r <= ^data_i;
      else if (shift_tail) head_par_r <= tail_par_r;
      if (load_tail_in)    tail_par_r <= ^data_i;
      if (deq && ((^head_r) != head_par_r)) err_r <= 1'b1;
    end
  end

  assign parity_err_o = err_r;
`else
  assign parity_err_o = 1'b0;
`endif

  assign v_o     = v_r;
  assign ready_o = ready_r;

  bsg_buf #(
    .width_p   (width_p),
    .harden_p  (harden_p),
    .vertical_p(vertical_p)
  ) u_buf (
    .i(head_r),
    .o(data_o)
  );

endmodule
